// File: rtl/hyst_pkt_fifo.sv
// hyst_pkt_fifo: single-clock packet FIFO that drops whole packets on overflow and holds off reads on underflow.
// Optional sampled fill/recovery status byte is built only when HL2_FIFO_STATUS_EN is defined.
module hyst_pkt_fifo #(
    parameter int WIDTH       = 24,
    parameter int USER_W      = 2,
    parameter int DEPTH       = 1024,
    parameter int AW          = $clog2(DEPTH),
    parameter int PUSH_RESUME = DEPTH / 2,
    parameter int POP_START   = DEPTH / 2,
    parameter bit DROP_MODE   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  wr_tdata,
    input  logic [USER_W-1:0] wr_tuser,
    input  logic              wr_tlast,
    input  logic              wr_tvalid,
    output logic              wr_tready,
    output logic [WIDTH-1:0]  rd_tdata,
    output logic [USER_W-1:0] rd_tuser,
    output logic              rd_tlast,
    output logic              rd_tvalid,
    input  logic              rd_tready,
    input  logic              rd_sample,
    output logic [AW:0]       used,
    output logic [7:0]        status
);
    localparam int EW = WIDTH + USER_W + 1;
    localparam logic [AW:0] FULL_LVL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] RESUME_LVL = (AW + 1)'(PUSH_RESUME);
    localparam logic [AW:0] START_LVL  = (AW + 1)'(POP_START);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          allow_push;
    logic          allow_pop;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign full      = (used == FULL_LVL);
    assign empty     = (used == '0);
    assign push      = wr_tvalid & ~full & (allow_push | ~DROP_MODE);
    assign pop       = rd_tready & rd_tvalid;
    assign wr_tready = DROP_MODE ? 1'b1 : ~full;
    assign rd_tvalid = allow_pop & ~empty;

    // Show-ahead head entry, forced to zero while reads are held off so stale RAM never leaks out.
    assign head = allow_pop ? mem[rd_ptr] : '0;
    assign {rd_tdata, rd_tuser, rd_tlast} = head;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_tdata, wr_tuser, wr_tlast};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   used <= used + (AW + 1)'(1);
                2'b01:   used <= used - (AW + 1)'(1);
                default: used <= used;
            endcase
        end
    end

    // A write attempt at full stops intake; it resumes only on a tlast once drained, so the next packet starts clean.
    always_ff @(posedge clk) begin
        if (rst || !DROP_MODE) begin
            allow_push <= 1'b1;
        end else if (wr_tvalid && full) begin
            allow_push <= 1'b0;
        end else if (wr_tvalid && wr_tlast && !allow_push && (used <= RESUME_LVL)) begin
            allow_push <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            allow_pop <= 1'b0;
        end else if (empty) begin
            allow_pop <= 1'b0;
        end else if (used >= START_LVL) begin
            allow_pop <= 1'b1;
        end
    end

`ifdef HL2_FIFO_STATUS_EN
    logic       recovery_flag;
    logic [6:0] used_top;

    // Small FIFOs have fewer than 7 occupancy bits, so the count is zero-extended instead.
    if (AW >= 6) begin : g_used_top_wide
        assign used_top = used[AW -: 7];
    end else begin : g_used_top_narrow
        assign used_top = 7'(used);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status        <= 8'h00;
            recovery_flag <= 1'b0;
        end else if (rd_sample) begin
            status        <= {recovery_flag, used_top};
            recovery_flag <= ~allow_pop | ~allow_push;
        end else if (!allow_pop || !allow_push) begin
            recovery_flag <= 1'b1;
        end
    end
`else
    logic unused_sample;
    assign unused_sample = rd_sample;
    assign status        = 8'h00;
`endif

endmodule

// File: tb/tb_hyst_pkt_fifo.sv
// tb_hyst_pkt_fifo: directed checks of fill, overflow drop, underflow hold-off, simultaneous push/pop,
// backpressure mode and the optional status byte, using DEPTH=16 with both thresholds at 8.
module tb_hyst_pkt_fifo;
    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] a_wr_tdata, a_rd_tdata;
    logic [1:0] a_wr_tuser, a_rd_tuser;
    logic       a_wr_tlast, a_wr_tvalid, a_wr_tready;
    logic       a_rd_tlast, a_rd_tvalid, a_rd_tready, a_rd_sample;
    logic [4:0] a_used;
    logic [7:0] a_status;

    logic [7:0] b_wr_tdata, b_rd_tdata;
    logic [1:0] b_wr_tuser, b_rd_tuser;
    logic       b_wr_tlast, b_wr_tvalid, b_wr_tready;
    logic       b_rd_tlast, b_rd_tvalid, b_rd_tready, b_rd_sample;
    logic [4:0] b_used;
    logic [7:0] b_status;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    hyst_pkt_fifo #(
        .WIDTH(8), .USER_W(2), .DEPTH(16), .PUSH_RESUME(8), .POP_START(8), .DROP_MODE(1'b1)
    ) dut_drop (
        .clk(clk), .rst(rst),
        .wr_tdata(a_wr_tdata), .wr_tuser(a_wr_tuser), .wr_tlast(a_wr_tlast),
        .wr_tvalid(a_wr_tvalid), .wr_tready(a_wr_tready),
        .rd_tdata(a_rd_tdata), .rd_tuser(a_rd_tuser), .rd_tlast(a_rd_tlast),
        .rd_tvalid(a_rd_tvalid), .rd_tready(a_rd_tready), .rd_sample(a_rd_sample),
        .used(a_used), .status(a_status)
    );

    hyst_pkt_fifo #(
        .WIDTH(8), .USER_W(2), .DEPTH(16), .PUSH_RESUME(8), .POP_START(8), .DROP_MODE(1'b0)
    ) dut_bp (
        .clk(clk), .rst(rst),
        .wr_tdata(b_wr_tdata), .wr_tuser(b_wr_tuser), .wr_tlast(b_wr_tlast),
        .wr_tvalid(b_wr_tvalid), .wr_tready(b_wr_tready),
        .rd_tdata(b_rd_tdata), .rd_tuser(b_rd_tuser), .rd_tlast(b_rd_tlast),
        .rd_tvalid(b_rd_tvalid), .rd_tready(b_rd_tready), .rd_sample(b_rd_sample),
        .used(b_used), .status(b_status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of the drop-mode FIFO; user is taken from the low data bits.
    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic last,
                                 input logic ready, input logic sample);
        a_wr_tvalid = valid;
        a_wr_tdata  = data;
        a_wr_tuser  = data[1:0];
        a_wr_tlast  = last;
        a_rd_tready = ready;
        a_rd_sample = sample;
        tick();
    endtask

    task automatic popExpect(input string tag, input logic [7:0] expected);
        checkOutput(tag, 32'(a_rd_tdata), 32'(expected));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [7:0] d;
        int         next_wr;
        int         next_rd;
        logic       wr_accept;

        rst = 1'b1;
        b_wr_tvalid = 1'b0; b_wr_tdata = '0; b_wr_tuser = '0; b_wr_tlast = 1'b0;
        b_rd_tready = 1'b0; b_rd_sample = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        checkOutput("reset_used", 32'(a_used), 32'd0);
        checkOutput("reset_rd_tvalid", 32'(a_rd_tvalid), 32'd0);
        checkOutput("reset_wr_tready", 32'(a_wr_tready), 32'd1);
        checkOutput("reset_status", 32'(a_status), 32'h00);

        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("fill7_used", 32'(a_used), 32'd7);
        checkOutput("fill7_rd_tvalid", 32'(a_rd_tvalid), 32'd0);
        checkOutput("fill7_rd_tdata", 32'(a_rd_tdata), 32'd0);
        applyStimulus(1'b1, 8'd8, 1'b1, 1'b0, 1'b0);
        checkOutput("fill8_rd_tvalid_early", 32'(a_rd_tvalid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("fill8_rd_tvalid", 32'(a_rd_tvalid), 32'd1);
        checkOutput("fill8_rd_tuser", 32'(a_rd_tuser), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) checkOutput("fill_rd_tlast", 32'(a_rd_tlast), 32'd1);
            popExpect("fill_order", 8'(k));
        end

        checkOutput("drain_rd_tvalid", 32'(a_rd_tvalid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("drain_rd_tdata_zero", 32'(a_rd_tdata), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1, 8'(8'h10 + k), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("under7_rd_tvalid", 32'(a_rd_tvalid), 32'd0);
        checkOutput("under7_rd_tdata", 32'(a_rd_tdata), 32'd0);
        applyStimulus(1'b1, 8'h18, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("under8_rd_tvalid", 32'(a_rd_tvalid), 32'd1);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef HL2_FIFO_STATUS_EN
        checkOutput("status_recovery", 32'(a_status), 32'h88);
`else
        checkOutput("status_off", 32'(a_status), 32'h00);
`endif
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef HL2_FIFO_STATUS_EN
        checkOutput("status_quiet", 32'(a_status), 32'h08);
`else
        checkOutput("status_off2", 32'(a_status), 32'h00);
`endif
        a_rd_sample = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            popExpect("under_order", 8'(8'h10 + k));
        end

        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, 8'(8'h20 + k), (k % 4) == 0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_used_sat", 32'(a_used), 32'd16);
        for (int k = 1; k <= 8; k++) begin
            popExpect("ovf_first_pops", 8'(8'h20 + k));
        end
        checkOutput("ovf_used_half", 32'(a_used), 32'd8);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 8'(8'h40 + k), k == 4, 1'b0, 1'b0);
        end
        checkOutput("ovf_resume_discard", 32'(a_used), 32'd8);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 8'(8'h50 + k), k == 4, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_next_pkt_used", 32'(a_used), 32'd12);
        for (int k = 9; k <= 16; k++) begin
            popExpect("ovf_old_tail", 8'(8'h20 + k));
        end
        for (int k = 1; k <= 4; k++) begin
            popExpect("ovf_new_pkt", 8'(8'h50 + k));
        end

        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 8'(8'h60 + k), (k % 4) == 0, 1'b0, 1'b0);
        end
        checkOutput("sim_full_used", 32'(a_used), 32'd16);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        checkOutput("sim_full_used15", 32'(a_used), 32'd15);
        for (int k = 2; k <= 11; k++) begin
            popExpect("sim_pops", 8'(8'h60 + k));
        end
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        checkOutput("sim_resume_used", 32'(a_used), 32'd5);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        checkOutput("sim_mid_used", 32'(a_used), 32'd5);
        for (int k = 13; k <= 16; k++) begin
            popExpect("sim_tail", 8'(8'h60 + k));
        end
        popExpect("sim_written", 8'h77);
        checkOutput("sim_end_used", 32'(a_used), 32'd0);

        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 8'(8'h80 + k), 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        applyStimulus(1'b1, 8'h84, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("midrst_used", 32'(a_used), 32'd0);
        checkOutput("midrst_rd_tdata", 32'(a_rd_tdata), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        next_wr = 1;
        next_rd = 1;
        for (int cyc = 0; cyc < 400 && next_rd <= 40; cyc++) begin
            if (cyc == 20) begin
                checkOutput("bp_full_used", 32'(b_used), 32'd16);
                checkOutput("bp_full_wr_tready", 32'(b_wr_tready), 32'd0);
            end
            b_wr_tvalid = (next_wr <= 40);
            b_wr_tdata  = 8'(next_wr);
            b_wr_tuser  = 2'(next_wr);
            b_wr_tlast  = (next_wr % 5) == 0;
            b_rd_tready = (cyc >= 20) && ((cyc % 3) != 0);
            wr_accept   = b_wr_tvalid && b_wr_tready;
            if (b_rd_tready && b_rd_tvalid) begin
                checkOutput("bp_order", 32'(b_rd_tdata), 32'(next_rd));
                next_rd++;
            end
            tick();
            if (wr_accept) next_wr++;
        end
        checkOutput("bp_all_delivered", 32'(next_rd), 32'd41);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
